// File: rtl/riscv_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding and register-index helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when an ID source operand is read and names the given destination.
  function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the scheduler (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic             Rs1UsedD;
  logic             Rs2UsedD;
  logic [4:0]       RdE;
  logic             MemToRegE;
  logic             BrMispredE;
  logic             DMemReqM;
  logic             DMemRdyM;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             StallW;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             FlushW;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, RdE, MemToRegE, BrMispredE, DMemReqM, DMemRdyM,
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW,
    input  MemTimeout, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, RdE, MemToRegE, BrMispredE, DMemReqM, DMemRdyM,
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW,
    output MemTimeout, StallCnt, FlushCnt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; synchronous rst/clr return it to zero (clr wins over inc).
module sat_counter #(
  parameter int           W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: combinational hazard priority encoder
// plus reset-flush/memory-wait FSM, sticky memory timeout and saturating perf counters.
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int RC_W   = (RST_FLUSH_CYCLES < 2) ? 1 : $clog2(RST_FLUSH_CYCLES + 1);
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  hz_state_e         state;
  logic [RC_W-1:0]   rst_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout;

  logic act;
  logic memwait;
  logic mispred;
  logic loaduse;
  logic rst_done;
  logic enter_run;
  logic timeout_hit;

  // Outside RUN/MEM_WAIT every segment is cleared and hazard inputs are ignored.
  assign act      = !rst && (state != ST_RESET);
  assign memwait  = act && hz.DMemReqM && !hz.DMemRdyM;
  assign mispred  = act && !memwait && hz.BrMispredE;
  assign loaduse  = act && !memwait && !hz.BrMispredE && hz.MemToRegE && (hz.RdE != REG_X0) &&
                    (src_hit(hz.Rs1UsedD, hz.Rs1D, hz.RdE) || src_hit(hz.Rs2UsedD, hz.Rs2D, hz.RdE));

  assign hz.StallF = memwait || loaduse;
  assign hz.StallD = memwait || loaduse;
  assign hz.StallE = memwait;
  assign hz.StallM = memwait;
  assign hz.StallW = 1'b0;
  assign hz.FlushD = !act || mispred;
  assign hz.FlushE = !act || mispred || loaduse;
  assign hz.FlushM = !act;
  assign hz.FlushW = !act || memwait;

  assign rst_done    = (rst_cnt <= RC_W'(1));
  assign enter_run   = !rst && (((state == ST_RESET) && rst_done) ||
                                ((state == ST_MEM_WAIT) && !memwait));
  assign timeout_hit = (MEM_TIMEOUT != 0) && memwait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RESET;
      rst_cnt     <= RC_W'(RST_FLUSH_CYCLES);
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          if (rst_done) state <= ST_RUN;
          else          rst_cnt <= rst_cnt - RC_W'(1);
        end
        ST_RUN:      if (memwait)  state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (!memwait) state <= ST_RUN;
        default:     state <= ST_RESET;
      endcase
      if (timeout_hit) mem_timeout <= 1'b1;
    end
  end

  assign hz.MemTimeout = mem_timeout;

  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (enter_run),
    .inc (memwait),
    .cnt (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (act && hz.StallF),
    .cnt (hz.StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (mispred),
    .cnt (hz.FlushCnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int RSTN  = 2;
  localparam int TMO   = 8;
  localparam int CNT_W = 32;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(
    .RST_FLUSH_CYCLES (RSTN),
    .MEM_TIMEOUT      (TMO),
    .CNT_W            (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // Hazard vector order: {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,FlushM,FlushW}
  typedef struct {
    logic [8:0]       hzv;
    logic             tmo;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   stim_done = 0;

  // Reference model state: cycles of reset flush left, consecutive wait run, sticky flag, counters.
  int               m_rleft;
  int               m_wrun;
  bit               m_tmo;
  logic [CNT_W-1:0] m_sc;
  logic [CNT_W-1:0] m_fc;

  task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req,
                     input int c);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
    end
  endtask

  task automatic model_reset();
    m_rleft = (RSTN == 0) ? 1 : RSTN;
    m_wrun  = 0;
    m_tmo   = 0;
    m_sc    = '0;
    m_fc    = '0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then advance the model.
  task automatic step();
    exp_t e;
    bit   mw, bp, lu;
    mw = 0; bp = 0; lu = 0;
    if (rst || m_rleft > 0) begin
      e.hzv = 9'b00000_1111;
    end else begin
      mw = hz.DMemReqM && !hz.DMemRdyM;
      bp = hz.BrMispredE;
      lu = hz.MemToRegE && (hz.RdE != 0) &&
           ((hz.Rs1UsedD && hz.Rs1D == hz.RdE) || (hz.Rs2UsedD && hz.Rs2D == hz.RdE));
      if (mw)      e.hzv = 9'b11110_0001;
      else if (bp) e.hzv = 9'b00000_1100;
      else if (lu) e.hzv = 9'b11000_0100;
      else         e.hzv = 9'b00000_0000;
    end
    e.tmo = m_tmo;
    e.sc  = m_sc;
    e.fc  = m_fc;
    e.cyc = cyc;
    q.push_back(e);

    if (rst) begin
      model_reset();
    end else if (m_rleft > 0) begin
      m_rleft--;
    end else begin
      if (mw) begin
        if (m_wrun < TMO) m_wrun++;
        if (TMO != 0 && m_wrun >= TMO) m_tmo = 1;
      end else begin
        m_wrun = 0;
      end
      if (e.hzv[8] && m_sc != '1) m_sc++;
      if (bp && !mw && m_fc != '1) m_fc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(input bit r, input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                     input bit u2, input logic [4:0] rde, input bit mtr, input bit mis,
                     input bit req, input bit rdy);
    rst = r;
    hz.Rs1D = rs1; hz.Rs2D = rs2; hz.Rs1UsedD = u1; hz.Rs2UsedD = u2;
    hz.RdE = rde; hz.MemToRegE = mtr; hz.BrMispredE = mis;
    hz.DMemReqM = req; hz.DMemRdyM = rdy;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, so each negedge consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hazard_vec", CNT_W'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW,
                                  hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}),
            CNT_W'(e.hzv), e.cyc);
        chk("mem_timeout", CNT_W'(hz.MemTimeout), CNT_W'(e.tmo), e.cyc);
        chk("stall_cnt", hz.StallCnt, e.sc, e.cyc);
        chk("flush_cnt", hz.FlushCnt, e.fc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1;
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1UsedD = 0; hz.Rs2UsedD = 0;
    hz.RdE = 0; hz.MemToRegE = 0; hz.BrMispredE = 0; hz.DMemReqM = 0; hz.DMemRdyM = 0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset: 3 cycles asserted, then the flush window, then idle.
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Load-use on rs2, then the same pattern against x0.
    drv(0, 0, 5, 0, 1, 5, 1, 0, 0, 0);
    idle(1);
    drv(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    drv(0, 3, 9, 1, 0, 3, 1, 0, 0, 0);
    idle(1);

    // Four memory-wait cycles, release on the fifth.
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Mispredict held through a 3-cycle wait, taking effect on release.
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);

    // Mispredict together with a load-use match.
    drv(0, 7, 0, 1, 0, 7, 1, 1, 0, 0);
    idle(1);

    // Long wait crossing the timeout, sticky afterwards, cleared by reset.
    for (int i = 0; i < 10; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic with occasional resets and forced long waits.
    for (int i = 0; i < 1500; i++) begin
      bit long_wait;
      long_wait = ($urandom_range(0, 199) == 0);
      if (long_wait) begin
        for (int k = 0; k < int'($urandom_range(6, 11)); k++)
          drv(0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 1, 0);
      end else begin
        drv(($urandom_range(0, 299) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
            5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 19) < 3), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 4));
      end
    end
    idle(2);
    stim_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!stim_done && guard < 60000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (!stim_done || q.size() != 0) begin
      n_bad++;
      $display("FAIL drain done=%0d actual_pending=%0d required_pending=0", stim_done, q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
